gap_pattern_detector: RTL

- Serial bit-stream classifier. Detects "1 0^n 1" patterns on a 1-bit input and reports the zero-gap length n with a one-cycle valid pulse.
- Generalises the fixed 2-bit pattern detector:
  - parametrised maximum gap;
  - sample-enable qualifier;
  - overlap mode;
  - explicit overflow reporting.
- Sits between a serial line sampler and downstream protocol/decode logic.

---
 rtl/gap_det_pkg.sv | 19 +
 rtl/gap_sat_counter.sv | 30 +++
 rtl/gap_pattern_detector.sv | 137 +++++++++++++
 3 files changed

// File: rtl/gap_det_pkg.sv
// Shared types and helpers for the gap pattern detector: FSM state encoding,
// default maximum gap and the counter width helper.
package gap_det_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      COUNT = 2'd2,
      OVF   = 2'd3
   } gap_state_t;

   localparam int GAP_MAX_DEFAULT = 4;

   // Counter must hold 0..max_gap inclusive; never narrower than one bit.
   function automatic int gap_cnt_w(input int max_gap);
      return (max_gap < 1) ? 1 : $clog2(max_gap + 1);
   endfunction

endpackage

// File: rtl/gap_sat_counter.sv
// Saturating up-counter for the zero-run length: synchronous clear,
// increment enable, and a sat flag raised when the count reaches MAX_VAL.
module gap_sat_counter
   import gap_det_pkg::*;
#(
   parameter int MAX_VAL = GAP_MAX_DEFAULT,
   parameter int CNT_W   = gap_cnt_w(MAX_VAL)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt,
   output logic             sat
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_VAL);

   assign sat = (cnt == MAX_CNT);

   // Clear wins over increment; at MAX_VAL the count freezes instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (inc && !sat) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/gap_pattern_detector.sv
// Serial "1 0^n 1" classifier reporting the zero-gap length with a one-cycle
// valid pulse. Define GAP_PATTERN_DETECTOR_MATCH_EN to add target_gap/match.
module gap_pattern_detector
   import gap_det_pkg::*;
#(
   parameter int MAX_GAP     = GAP_MAX_DEFAULT,
   parameter int CNT_W       = gap_cnt_w(MAX_GAP),
   parameter int OVERLAP     = 1,
   parameter int REPORT_ZERO = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             x,
   input  logic             x_en,
   output logic             gap_valid,
   output logic [CNT_W-1:0] gap_len,
   output logic             gap_ovf,
   output logic             armed
`ifdef GAP_PATTERN_DETECTOR_MATCH_EN
   ,
   input  logic [CNT_W-1:0] target_gap,
   output logic             match
`endif
);

   gap_state_t       state;
   gap_state_t       nxt;
   logic             cnt_clr;
   logic             cnt_inc;
   logic [CNT_W-1:0] cnt;
   logic             cnt_sat;

   logic             report_p0;
   logic             rep_ovf_p0;
   logic [CNT_W-1:0] rep_len_p0;
   gap_state_t       after_close;

   assign after_close = (OVERLAP != 0) ? ARMED : IDLE;

   gap_sat_counter #(
      .MAX_VAL (MAX_GAP),
      .CNT_W   (CNT_W)
   ) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (cnt_inc),
      .cnt (cnt),
      .sat (cnt_sat)
   );

   // Stage p0: next-state and report decode on the consumed sample
   always_comb begin
      nxt        = state;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      report_p0  = 1'b0;
      rep_ovf_p0 = 1'b0;
      rep_len_p0 = '0;
      if (x_en) begin
         case (state)
            IDLE: begin
               if (x) begin
                  nxt     = ARMED;
                  cnt_clr = 1'b1;
               end
            end
            ARMED: begin
               if (!x) begin
                  nxt     = COUNT;
                  cnt_inc = 1'b1;
               end else begin
                  report_p0 = (REPORT_ZERO != 0);
                  nxt       = after_close;
                  cnt_clr   = 1'b1;
               end
            end
            COUNT: begin
               if (!x) begin
                  if (cnt_sat) begin
                     nxt = OVF;
                  end else begin
                     cnt_inc = 1'b1;
                  end
               end else begin
                  report_p0  = 1'b1;
                  rep_len_p0 = cnt;
                  nxt        = after_close;
                  cnt_clr    = 1'b1;
               end
            end
            OVF: begin
               if (x) begin
                  report_p0  = 1'b1;
                  rep_ovf_p0 = 1'b1;
                  nxt        = after_close;
                  cnt_clr    = 1'b1;
               end
            end
            default: begin
               nxt     = IDLE;
               cnt_clr = 1'b1;
            end
         endcase
      end
   end

   // Stage p1: registered state and report outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         gap_valid <= 1'b0;
         gap_len   <= '0;
         gap_ovf   <= 1'b0;
      end else begin
         state     <= nxt;
         gap_valid <= report_p0;
         if (report_p0) begin
            gap_len <= rep_len_p0;
            gap_ovf <= rep_ovf_p0;
         end
      end
   end

   assign armed = (state != IDLE);

`ifdef GAP_PATTERN_DETECTOR_MATCH_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         match <= 1'b0;
      end else begin
         match <= report_p0 && !rep_ovf_p0 && (rep_len_p0 == target_gap);
      end
   end
`endif

endmodule
